return_addr_stack: RTL and testbench
====================================

// Module: return_addr_stack
// PURPOSE
//  Circular return-address stack feeding the fetch-stage predictor. Consumes the branch decoder's
//  is_call/is_return classification: calls push the link address (PC+8, past the delay slot) and
//  returns pop it. Provides the predicted JR $31 target plus a checkpoint/restore path so that a
//  mispredict flush rewinds speculative pushes and pops.
// PARAMETERS
//  DEPTH       8    number of entries; power of two, >= 2
//  ADDR_W      32   width of a stored return address
//  PTR_W       $clog2(DEPTH)  derived, not overridable
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  flush        in   1        clear stack (exception/ERET); highest priority
//  recover      in   1        restore tos/count from recover_ptr/recover_cnt
//  recover_ptr  in   PTR_W    checkpointed top-of-stack index
//  recover_cnt  in   PTR_W+1  checkpointed occupancy
//  push         in   1        decoded call (JAL, JALR rd=$31, BLTZAL/BGEZAL)
//  push_addr    in   ADDR_W   link address to store
//  pop          in   1        decoded return (JR $31, JALR rs=$31)
//  top_addr     out  ADDR_W   predicted return target = entry at tos
//  top_valid    out  1        count != 0
//  ckpt_ptr     out  PTR_W    current tos, captured with each in-flight branch
//  ckpt_cnt     out  PTR_W+1  current count
//  overflow     out  1        registered: last push overwrote a live entry
// BEHAVIOUR
//  State: mem[DEPTH] of ADDR_W, tos (PTR_W), count (PTR_W+1, 0..DEPTH), overflow flag.
//  Reset (rst_n=0, async): tos=DEPTH-1, count=0, overflow=0; mem contents not cleared.
//   Outputs after reset: top_valid=0, ckpt_ptr=DEPTH-1, ckpt_cnt=0, overflow=0, top_addr=mem[DEPTH-1].
//  Outputs are combinational from registered state only; no input->output combinational path.
//   The prediction made in a cycle reflects updates from earlier cycles only.
//  An update is visible on top_addr/top_valid the cycle after the triggering edge (1-cycle latency).
//  Priority per cycle: flush > recover > push/pop.
//   flush:   tos=DEPTH-1, count=0, overflow=0; push/pop/recover ignored.
//   recover: tos=recover_ptr, count=recover_cnt, overflow=0; push/pop same cycle ignored.
//   recover_cnt > DEPTH is clamped to DEPTH.
//  Operation cases (no flush/recover):
//   push only: tos=tos+1 (mod DEPTH); mem[tos+1]=push_addr; count=min(count+1,DEPTH).
//     If count==DEPTH before the push, the oldest entry is overwritten: overflow=1, count stays DEPTH.
//   pop only, count>0: tos=tos-1 (mod DEPTH); count=count-1.
//   pop only, count==0: underflow; no state change, overflow unchanged.
//   push&pop (JALR $31,$31, or decoder call+return same cycle): pop-then-push, i.e.
//     mem[tos]=push_addr; tos and count unchanged. When count==0: mem[tos+1]=push_addr, tos+1,
//     count=1, as for push only.
//   neither: hold. overflow clears on any cycle that completes a pop.
//  Pointer arithmetic wraps modulo DEPTH; count never wraps.
//  A recovered ptr/cnt may reference entries overwritten since the checkpoint was taken; that
//  corruption is a tolerated mispredict, not an error, and is not detected.
//  rst_n asserting mid-stream aborts the current update; no partial write is visible after release.
// TESTING
//  T1 reset then push 0x8000_0010, 0x8000_0020 -> top_addr 0x8000_0020, ckpt_cnt 2; pop -> top 0x8000_0010, cnt 1.
//  T2 DEPTH=8: push 9 addrs A1..A9 -> overflow=1, cnt 8; 8 pops return A9..A2 in order, then top_valid=0.
//  T3 pop with cnt 0 -> tos, count, top_valid unchanged (0); then push X -> top_addr X, cnt 1.
//  T4 cnt 2 top B, push&pop with Y -> top Y, cnt 2, ckpt_ptr unchanged; push&pop at cnt 0 -> cnt 1, top Y2.
//  T5 save ckpt (ptr p, cnt 3), then push 2 and pop 4, then recover -> ckpt_ptr p, cnt 3, top = pre-save top.
//  T6 flush asserted with push, and rst_n dropped mid-burst -> cnt 0, top_valid 0 next cycle; no entry written.

Source files
------------

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return-address stack with checkpoint/restore for the fetch predictor
module return_addr_stack #(
  parameter  int DEPTH  = 8,
  parameter  int ADDR_W = 32,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              recover,
  input  logic [PTR_W-1:0]  recover_ptr,
  input  logic [PTR_W:0]    recover_cnt,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] top_addr,
  output logic              top_valid,
  output logic [PTR_W-1:0]  ckpt_ptr,
  output logic [PTR_W:0]    ckpt_cnt,
  output logic              overflow
);

  localparam logic [PTR_W-1:0] TOS_RST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  tos_q, tos_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  tos_inc, tos_dec;
  logic              empty, full;

  assign tos_inc = tos_q + 1'b1;
  assign tos_dec = tos_q - 1'b1;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_MAX);

  always_comb begin
    tos_d  = tos_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    wr_en  = 1'b0;
    wr_idx = tos_q;
    if (flush) begin
      tos_d = TOS_RST;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (recover) begin
      tos_d = recover_ptr;
      cnt_d = (recover_cnt > CNT_MAX) ? CNT_MAX : recover_cnt;
      ovf_d = 1'b0;
    end else if (push && (!pop || empty)) begin
      // Plain push; a push+pop on an empty stack behaves the same since the pop underflows.
      wr_en  = 1'b1;
      wr_idx = tos_inc;
      tos_d  = tos_inc;
      ovf_d  = full;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (push && pop) begin
      wr_en = 1'b1;
      ovf_d = 1'b0;
    end else if (pop && !empty) begin
      tos_d = tos_dec;
      cnt_d = cnt_q - 1'b1;
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = push_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q <= TOS_RST;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entries are not cleared; writes are blocked while reset is held so none leak past release.
  always_ff @(posedge clk) begin
    if (rst_n) mem_q <= mem_d;
  end

  assign top_addr  = mem_q[tos_q];
  assign top_valid = !empty;
  assign ckpt_ptr  = tos_q;
  assign ckpt_cnt  = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - directed self-checking bench for return_addr_stack
module tb_return_addr_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, recover, push, pop;
  logic [2:0]  recover_ptr;
  logic [3:0]  recover_cnt;
  logic [31:0] push_addr;
  logic [31:0] top_addr;
  logic        top_valid;
  logic [2:0]  ckpt_ptr;
  logic [3:0]  ckpt_cnt;
  logic        overflow;

  int n_checks = 0;
  int n_fails  = 0;

  return_addr_stack #(.DEPTH(8), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .recover(recover),
    .recover_ptr(recover_ptr), .recover_cnt(recover_cnt),
    .push(push), .push_addr(push_addr), .pop(pop),
    .top_addr(top_addr), .top_valid(top_valid), .ckpt_ptr(ckpt_ptr),
    .ckpt_cnt(ckpt_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic state(input string tag, input logic [2:0] p, input logic [3:0] c);
    check({tag, ".ptr"}, 32'(ckpt_ptr), 32'(p));
    check({tag, ".cnt"}, 32'(ckpt_cnt), 32'(c));
    check({tag, ".valid"}, 32'(top_valid), 32'(c != 0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    flush = 0; recover = 0; push = 0; pop = 0;
  endtask

  task automatic do_push(input logic [31:0] a);
    push = 1; push_addr = a; step();
  endtask

  task automatic do_pop();
    pop = 1; step();
  endtask

  task automatic do_pp(input logic [31:0] a);
    push = 1; pop = 1; push_addr = a; step();
  endtask

  task automatic do_recover(input logic [2:0] p, input logic [3:0] c);
    recover = 1; recover_ptr = p; recover_cnt = c; step();
  endtask

  initial begin
    rst_n = 0; flush = 0; recover = 0; push = 0; pop = 0;
    recover_ptr = 0; recover_cnt = 0; push_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    state("reset", 3'd7, 4'd0);
    check("reset.ovf", 32'(overflow), 0);

    // T1
    do_push(32'h8000_0010);
    do_push(32'h8000_0020);
    check("t1.top2", top_addr, 32'h8000_0020);
    state("t1.push2", 3'd1, 4'd2);
    do_pop();
    check("t1.top1", top_addr, 32'h8000_0010);
    state("t1.pop", 3'd0, 4'd1);

    // T3
    do_pop();
    state("t3.empty", 3'd7, 4'd0);
    do_pop();
    state("t3.underflow", 3'd7, 4'd0);
    check("t3.uf_ovf", 32'(overflow), 0);
    do_push(32'h1234_5678);
    check("t3.top", top_addr, 32'h1234_5678);
    state("t3.push", 3'd0, 4'd1);

    // T4
    do_push(32'hB000_0000);
    check("t4.topB", top_addr, 32'hB000_0000);
    do_pp(32'hCAFE_0004);
    check("t4.topY", top_addr, 32'hCAFE_0004);
    state("t4.pp", 3'd1, 4'd2);
    do_pop();
    check("t4.under", top_addr, 32'h1234_5678);
    do_pop();
    state("t4.empty", 3'd7, 4'd0);
    do_pp(32'h0000_00C8);
    check("t4.topY2", top_addr, 32'h0000_00C8);
    state("t4.pp0", 3'd0, 4'd1);
    do_pop();
    state("t4.drain", 3'd7, 4'd0);

    // T2: A_i = 0xA000_0000 + 4*i, first lands in mem[0]
    for (int i = 1; i <= 8; i++) do_push(32'hA000_0000 + 32'(4 * i));
    state("t2.full", 3'd7, 4'd8);
    check("t2.no_ovf", 32'(overflow), 0);
    do_push(32'hA000_0024);
    state("t2.wrap", 3'd0, 4'd8);
    check("t2.ovf", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2.pop%0d", i), top_addr, 32'hA000_0000 + 32'(4 * (9 - i)));
      do_pop();
      if (i == 0) check("t2.ovf_clr", 32'(overflow), 0);
    end
    state("t2.drained", 3'd0, 4'd0);

    // T5: C1..C3 at mem[1..3], D1/D2 at mem[4..5]
    do_push(32'hC000_0001);
    do_push(32'hC000_0002);
    do_push(32'hC000_0003);
    state("t5.save", 3'd3, 4'd3);
    do_push(32'hD000_0001);
    do_push(32'hD000_0002);
    repeat (4) do_pop();
    state("t5.spec", 3'd1, 4'd1);
    push = 1; push_addr = 32'hEEEE_EEEE;
    do_recover(3'd3, 4'd3);
    state("t5.recover", 3'd3, 4'd3);
    check("t5.top", top_addr, 32'hC000_0003);
    do_recover(3'd2, 4'd15);
    state("t5.clamp", 3'd2, 4'd8);
    check("t5.clamp_top", top_addr, 32'hC000_0002);

    // T6
    push = 1; push_addr = 32'hF1F1_F1F1; recover = 1; recover_ptr = 3'd5; recover_cnt = 4'd2;
    flush = 1; step();
    state("t6.flush", 3'd7, 4'd0);
    check("t6.flush_ovf", 32'(overflow), 0);
    check("t6.top7", top_addr, 32'hA000_0020);
    do_recover(3'd3, 4'd1);
    check("t6.no_write", top_addr, 32'hC000_0003);
    flush = 1; step();
    do_push(32'hE000_0001);
    state("t6.e1", 3'd0, 4'd1);
    push = 1; push_addr = 32'hE000_0002;
    #1 rst_n = 0;
    #1;
    state("t6.rst_async", 3'd7, 4'd0);
    @(posedge clk);
    #3 rst_n = 1;
    push = 0;
    @(posedge clk);
    #1;
    state("t6.post_rst", 3'd7, 4'd0);
    do_recover(3'd1, 4'd1);
    check("t6.rst_no_write", top_addr, 32'hC000_0001);
    do_recover(3'd0, 4'd1);
    check("t6.e1_kept", top_addr, 32'hE000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
